fft16_scheduler: RTL

//  Upstream sequencer/working store for butterfly2 in the 16-point radix-2 DIT FFT.
//  - Accepts 16 complex samples and stores them in bit-reversed order.
//  - Issues 4 stages x 8 butterflies with operands and twiddle, waits for done, writes results back in place.
//  - Streams the 16 results out in natural order.

---
 rtl/fft16_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fft16_scheduler.sv
// fft16_scheduler: bit-reversed working store and stage/butterfly sequencer for a 16-point radix-2 DIT FFT.
// Loads 16 samples, drives 32 butterfly operations through an external butterfly, then streams X[0..15].
module fft16_scheduler #(
  parameter int WORD_SIZE  = 16,
  parameter int FRACTION   = 8,
  parameter int BF_TIMEOUT = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic signed [WORD_SIZE-1:0] i_in_re,
  input  logic signed [WORD_SIZE-1:0] i_in_im,
  output logic signed [WORD_SIZE-1:0] o_bf_in0_re,
  output logic signed [WORD_SIZE-1:0] o_bf_in0_im,
  output logic signed [WORD_SIZE-1:0] o_bf_in1_re,
  output logic signed [WORD_SIZE-1:0] o_bf_in1_im,
  output logic signed [WORD_SIZE-1:0] o_bf_tw_re,
  output logic signed [WORD_SIZE-1:0] o_bf_tw_im,
  output logic                        o_bf_start,
  input  logic                        i_bf_done,
  input  logic signed [WORD_SIZE-1:0] i_bf_out0_re,
  input  logic signed [WORD_SIZE-1:0] i_bf_out0_im,
  input  logic signed [WORD_SIZE-1:0] i_bf_out1_re,
  input  logic signed [WORD_SIZE-1:0] i_bf_out1_im,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic signed [WORD_SIZE-1:0] o_out_re,
  output logic signed [WORD_SIZE-1:0] o_out_im,
  output logic                        o_out_last,
  output logic                        o_busy,
  output logic                        o_error
);
  localparam int WS = WORD_SIZE;
  localparam int CW = $clog2(BF_TIMEOUT + 1);
  // cos/sin magnitudes of multiples of pi/8 in 16-bit fixed point, rescaled to FRACTION with rounding
  localparam longint C0 = 65536, C1 = 60547, C2 = 46341, C3 = 25080;
  function automatic logic signed [WS-1:0] tw_q(input longint c, input logic neg);
    longint m;
    m = (c * (longint'(1) << FRACTION) + 32768) >>> 16;
    return neg ? WS'(-m) : WS'(m);
  endfunction
  localparam logic signed [WS-1:0] TW_RE [8] = '{tw_q(C0, 1'b0), tw_q(C1, 1'b0), tw_q(C2, 1'b0), tw_q(C3, 1'b0),
                                                tw_q(0, 1'b0), tw_q(C3, 1'b1), tw_q(C2, 1'b1), tw_q(C1, 1'b1)};
  localparam logic signed [WS-1:0] TW_IM [8] = '{tw_q(0, 1'b0), tw_q(C3, 1'b1), tw_q(C2, 1'b1), tw_q(C1, 1'b1),
                                                tw_q(C0, 1'b1), tw_q(C1, 1'b1), tw_q(C2, 1'b1), tw_q(C3, 1'b1)};
  typedef enum logic [2:0] {S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_UNLOAD} state_t;
  state_t                r_state;
  logic signed [WS-1:0]  r_mem_re [16];
  logic signed [WS-1:0]  r_mem_im [16];
  logic [3:0]            r_n, r_k, r_idx0, r_idx1;
  logic [1:0]            r_s;
  logic [2:0]            r_b;
  logic [CW-1:0]         r_wait;
  logic signed [WS-1:0]  r_res0_re, r_res0_im, r_res1_re, r_res1_im;
  logic                  w_accept, w_last_bf, w_out_fire, w_to_issue;
  logic [3:0]            w_rev, w_k_next, w_b4, w_half, w_mask, w_pos, w_idx0, w_idx1;
  logic [1:0]            w_ns;
  logic [2:0]            w_nb, w_tk;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_last_bf  = (r_s == 2'd3) && (r_b == 3'd7);
  assign w_out_fire = o_out_valid & i_out_ready;
  assign w_to_issue = (r_state == S_LOAD && w_accept && r_n == 4'd15) || (r_state == S_WRITE && !w_last_bf);
  assign w_rev      = {r_n[0], r_n[1], r_n[2], r_n[3]};
  assign w_k_next   = r_k + 4'd1;
  // coordinates of the butterfly about to be issued: (0,0) after LOAD, successor of (r_s,r_b) after WRITE
  assign w_nb       = (r_state == S_WRITE) ? r_b + 3'd1 : 3'd0;
  assign w_ns       = (r_state == S_WRITE) ? r_s + {1'b0, &r_b} : 2'd0;
  assign w_b4       = {1'b0, w_nb};
  assign w_half     = 4'd1 << w_ns;
  assign w_mask     = w_half - 4'd1;
  assign w_pos      = w_b4 & w_mask;
  assign w_idx0     = ((w_b4 & ~w_mask) << 1) | w_pos;
  assign w_idx1     = w_idx0 | w_half;
  assign w_tk       = 3'(w_pos << (2'd3 - w_ns));
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_LOAD;
      r_n         <= 4'd0;
      r_k         <= 4'd0;
      r_s         <= 2'd0;
      r_b         <= 3'd0;
      r_idx0      <= 4'd0;
      r_idx1      <= 4'd0;
      r_wait      <= '0;
      r_res0_re   <= '0;
      r_res0_im   <= '0;
      r_res1_re   <= '0;
      r_res1_im   <= '0;
      o_in_ready  <= 1'b1;
      o_bf_start  <= 1'b0;
      o_bf_in0_re <= '0;
      o_bf_in0_im <= '0;
      o_bf_in1_re <= '0;
      o_bf_in1_im <= '0;
      o_bf_tw_re  <= '0;
      o_bf_tw_im  <= '0;
      o_out_valid <= 1'b0;
      o_out_re    <= '0;
      o_out_im    <= '0;
      o_out_last  <= 1'b0;
      o_busy      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_bf_start <= 1'b0;
      case (r_state)
        S_LOAD: if (w_accept) begin
          r_mem_re[w_rev] <= i_in_re;
          r_mem_im[w_rev] <= i_in_im;
          r_n             <= r_n + 4'd1;
          o_error         <= 1'b0;
          if (r_n == 4'd15) begin
            o_in_ready <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (i_bf_done) begin
          r_res0_re <= i_bf_out0_re;
          r_res0_im <= i_bf_out0_im;
          r_res1_re <= i_bf_out1_re;
          r_res1_im <= i_bf_out1_im;
          r_state   <= S_WRITE;
        end else if (r_wait == CW'(BF_TIMEOUT)) begin
          r_state    <= S_LOAD;
          r_n        <= 4'd0;
          o_in_ready <= 1'b1;
          o_busy     <= 1'b0;
          o_error    <= 1'b1;
        end else r_wait <= r_wait + 1'b1;
        S_WRITE: begin
          r_mem_re[r_idx0] <= r_res0_re;
          r_mem_im[r_idx0] <= r_res0_im;
          r_mem_re[r_idx1] <= r_res1_re;
          r_mem_im[r_idx1] <= r_res1_im;
          if (w_last_bf) begin
            r_state     <= S_UNLOAD;
            r_k         <= 4'd0;
            o_out_valid <= 1'b1;
            o_out_re    <= r_mem_re[0];
            o_out_im    <= r_mem_im[0];
            o_out_last  <= 1'b0;
          end
        end
        S_UNLOAD: if (w_out_fire) begin
          if (o_out_last) begin
            r_state     <= S_LOAD;
            r_n         <= 4'd0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
            o_in_ready  <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            r_k        <= w_k_next;
            o_out_re   <= r_mem_re[w_k_next];
            o_out_im   <= r_mem_im[w_k_next];
            o_out_last <= (w_k_next == 4'd15);
          end
        end
        default: r_state <= S_LOAD;
      endcase
      // operands are read straight from the store: the slot being written this cycle (last load
      // sample or previous butterfly result) never overlaps the next butterfly's pair
      if (w_to_issue) begin
        r_state     <= S_ISSUE;
        r_s         <= w_ns;
        r_b         <= w_nb;
        r_idx0      <= w_idx0;
        r_idx1      <= w_idx1;
        r_wait      <= '0;
        o_bf_start  <= 1'b1;
        o_bf_in0_re <= r_mem_re[w_idx0];
        o_bf_in0_im <= r_mem_im[w_idx0];
        o_bf_in1_re <= r_mem_re[w_idx1];
        o_bf_in1_im <= r_mem_im[w_idx1];
        o_bf_tw_re  <= TW_RE[w_tk];
        o_bf_tw_im  <= TW_IM[w_tk];
      end
    end
  end
endmodule
